// File: rtl/mem_wb_pipe_pkg.sv
// Shared widths and helpers for the MEM->WB pipeline register slice.
// The lane-slice macro selects lane i of a packed per-lane bus of width w.
`ifndef MEM_WB_PIPE_PKG_SV
`define MEM_WB_PIPE_PKG_SV

`define MWB_LANE(i, w) (i)*(w) +: (w)

package mem_wb_pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

endpackage

`endif

// File: rtl/wb_entry_reg.sv
// One writeback entry (valid plus all fields) with load/clear controls.
// Lane write enables are qualified against the zero register at capture.
module wb_entry_reg
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LANES  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     load,
    input  logic [LANES-1:0]         d_we,
    input  logic [LANES*ADDR_W-1:0]  d_dest,
    input  logic [LANES*DATA_W-1:0]  d_result,
    input  logic                     d_hilo_we,
    input  logic [DATA_W-1:0]        d_hi,
    input  logic [DATA_W-1:0]        d_lo,
    output logic                     q_valid,
    output logic [LANES-1:0]         q_we,
    output logic [LANES*ADDR_W-1:0]  q_dest,
    output logic [LANES*DATA_W-1:0]  q_result,
    output logic                     q_hilo_we,
    output logic [DATA_W-1:0]        q_hi,
    output logic [DATA_W-1:0]        q_lo
);

    logic                    valid_q;
    logic [LANES-1:0]        we_q;
    logic [LANES-1:0]        we_d;
    logic [LANES*ADDR_W-1:0] dest_q;
    logic [LANES*DATA_W-1:0] result_q;
    logic                    hilo_we_q;
    logic [DATA_W-1:0]       hi_q;
    logic [DATA_W-1:0]       lo_q;

    always_comb begin
        we_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            we_d[i] = d_we[i] && (d_dest[`MWB_LANE(i, ADDR_W)] != ADDR_W'(ZERO_REG));
        end
    end

    // Clear drops the enables too, so a killed entry can never write even if
    // a downstream consumer ignores valid; data fields are left stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            we_q      <= '0;
            dest_q    <= '0;
            result_q  <= '0;
            hilo_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (clr) begin
            valid_q   <= 1'b0;
            we_q      <= '0;
            hilo_we_q <= 1'b0;
        end else if (load) begin
            valid_q   <= 1'b1;
            we_q      <= we_d;
            dest_q    <= d_dest;
            result_q  <= d_result;
            hilo_we_q <= d_hilo_we;
            hi_q      <= d_hi;
            lo_q      <= d_lo;
        end
    end

    assign q_valid   = valid_q;
    assign q_we      = we_q;
    assign q_dest    = dest_q;
    assign q_result  = result_q;
    assign q_hilo_we = hilo_we_q;
    assign q_hi      = hi_q;
    assign q_lo      = lo_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: LANES writeback lanes plus HI/LO, valid/ready
// handshake with an optional 2-entry skid buffer and synchronous flush.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned LANES   = 1,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_we,
    input  logic [LANES*ADDR_W-1:0]  in_dest,
    input  logic [LANES*DATA_W-1:0]  in_result,
    input  logic                     in_hilo_we,
    input  logic [DATA_W-1:0]        in_hi,
    input  logic [DATA_W-1:0]        in_lo,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         wb_we,
    output logic [LANES*ADDR_W-1:0]  wb_dest,
    output logic [LANES*DATA_W-1:0]  wb_result,
    output logic                     wb_hilo_we,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo
);

    logic                    main_valid;
    logic [LANES-1:0]        main_we;
    logic [LANES*ADDR_W-1:0] main_dest;
    logic [LANES*DATA_W-1:0] main_result;
    logic                    main_hilo_we;
    logic [DATA_W-1:0]       main_hi;
    logic [DATA_W-1:0]       main_lo;

    logic                    skid_valid;
    logic [LANES-1:0]        skid_we;
    logic [LANES*ADDR_W-1:0] skid_dest;
    logic [LANES*DATA_W-1:0] skid_result;
    logic                    skid_hilo_we;
    logic [DATA_W-1:0]       skid_hi;
    logic [DATA_W-1:0]       skid_lo;

    logic                    main_load;
    logic                    main_clr;
    logic                    main_from_skid;
    logic                    skid_load;
    logic                    skid_clr;
    logic                    accept;

    logic [LANES-1:0]        main_d_we;
    logic [LANES*ADDR_W-1:0] main_d_dest;
    logic [LANES*DATA_W-1:0] main_d_result;
    logic                    main_d_hilo_we;
    logic [DATA_W-1:0]       main_d_hi;
    logic [DATA_W-1:0]       main_d_lo;

    generate
        if (SKID_EN) begin : g_rdy_skid
            assign in_ready = !skid_valid;
        end else begin : g_rdy_single
            assign in_ready = out_ready || !main_valid;
        end
    endgenerate

    assign accept = in_valid && in_ready;

    // A pending skid entry always drains into main first; in_ready is low
    // whenever skid holds data, so no input can race that move.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (skid_valid) begin
            if (out_ready) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end
        end else if (accept) begin
            if (!main_valid || out_ready) begin
                main_load = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end else if (main_valid && out_ready) begin
            main_clr = 1'b1;
        end
    end

    always_comb begin
        if (main_from_skid) begin
            main_d_we      = skid_we;
            main_d_dest    = skid_dest;
            main_d_result  = skid_result;
            main_d_hilo_we = skid_hilo_we;
            main_d_hi      = skid_hi;
            main_d_lo      = skid_lo;
        end else begin
            main_d_we      = in_we;
            main_d_dest    = in_dest;
            main_d_result  = in_result;
            main_d_hilo_we = in_hilo_we;
            main_d_hi      = in_hi;
            main_d_lo      = in_lo;
        end
    end

    wb_entry_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .clr       (main_clr),
        .load      (main_load),
        .d_we      (main_d_we),
        .d_dest    (main_d_dest),
        .d_result  (main_d_result),
        .d_hilo_we (main_d_hilo_we),
        .d_hi      (main_d_hi),
        .d_lo      (main_d_lo),
        .q_valid   (main_valid),
        .q_we      (main_we),
        .q_dest    (main_dest),
        .q_result  (main_result),
        .q_hilo_we (main_hilo_we),
        .q_hi      (main_hi),
        .q_lo      (main_lo)
    );

    generate
        if (SKID_EN) begin : g_skid
            wb_entry_reg #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .LANES  (LANES)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .clr       (skid_clr),
                .load      (skid_load),
                .d_we      (in_we),
                .d_dest    (in_dest),
                .d_result  (in_result),
                .d_hilo_we (in_hilo_we),
                .d_hi      (in_hi),
                .d_lo      (in_lo),
                .q_valid   (skid_valid),
                .q_we      (skid_we),
                .q_dest    (skid_dest),
                .q_result  (skid_result),
                .q_hilo_we (skid_hilo_we),
                .q_hi      (skid_hi),
                .q_lo      (skid_lo)
            );
        end else begin : g_no_skid
            assign skid_valid   = 1'b0;
            assign skid_we      = '0;
            assign skid_dest    = '0;
            assign skid_result  = '0;
            assign skid_hilo_we = 1'b0;
            assign skid_hi      = '0;
            assign skid_lo      = '0;
        end
    endgenerate

    assign out_valid  = main_valid;
    assign wb_we      = main_we & {LANES{main_valid}};
    assign wb_dest    = main_dest;
    assign wb_result  = main_result;
    assign wb_hilo_we = main_hilo_we & main_valid;
    assign wb_hi      = main_hi;
    assign wb_lo      = main_lo;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed plus randomized bench for mem_wb_pipe (LANES=2, skid enabled),
// checked each cycle against a queue-based model of held entries.
module tb_mem_wb_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned L  = 2;

    typedef struct packed {
        logic [L-1:0]    we;
        logic [L*AW-1:0] dest;
        logic [L*DW-1:0] res;
        logic            hwe;
        logic [DW-1:0]   hi;
        logic [DW-1:0]   lo;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [L-1:0]    in_we, wb_we;
    logic [L*AW-1:0] in_dest, wb_dest;
    logic [L*DW-1:0] in_result, wb_result;
    logic            in_hilo_we, wb_hilo_we;
    logic [DW-1:0]   in_hi, in_lo, wb_hi, wb_lo;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t mq[$];
    bit   stream_on = 1'b0;
    int   sent_id = 0;
    int   next_id = 0;
    int   done_cnt;

    mem_wb_pipe #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .LANES   (L),
        .SKID_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_we      (in_we),
        .in_dest    (in_dest),
        .in_result  (in_result),
        .in_hilo_we (in_hilo_we),
        .in_hi      (in_hi),
        .in_lo      (in_lo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_we      (wb_we),
        .wb_dest    (wb_dest),
        .wb_result  (wb_result),
        .wb_hilo_we (wb_hilo_we),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t cur_in();
        ent_t e;
        e.dest = in_dest;
        e.res  = in_result;
        e.hwe  = in_hilo_we;
        e.hi   = in_hi;
        e.lo   = in_lo;
        for (int i = 0; i < L; i++) begin
            e.we[i] = in_we[i] && (((in_dest >> (i * AW)) & 10'h1F) != 0);
        end
        return e;
    endfunction

    task automatic check_outputs();
        chk("in_ready", in_ready, mq.size() < 2);
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("wb_we", wb_we, mq[0].we);
            chk("wb_dest", wb_dest, mq[0].dest);
            chk("wb_result", wb_result, mq[0].res);
            chk("wb_hilo_we", wb_hilo_we, mq[0].hwe);
            chk("wb_hi", wb_hi, mq[0].hi);
            chk("wb_lo", wb_lo, mq[0].lo);
        end else begin
            chk("idle_we", wb_we, '0);
            chk("idle_hilo_we", wb_hilo_we, 1'b0);
        end
        if (stream_on && out_valid && out_ready) begin
            chk("stream_order", wb_result[DW-1:0], next_id);
            next_id++;
        end
    endtask

    task automatic model_update();
        bit acc, pop;
        if (rst || flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            pop = out_ready && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(cur_in());
                if (stream_on) sent_id++;
            end
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] d0, input logic [DW-1:0] r0,
                         input logic [4:0] d1, input logic [DW-1:0] r1, input logic [1:0] we);
        in_valid   = v;
        in_dest    = {d1, d0};
        in_result  = {r1, r0};
        in_we      = we;
        in_hilo_we = 1'b0;
        in_hi      = '0;
        in_lo      = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        @(negedge clk);
        @(posedge clk); model_update(); @(negedge clk);
        @(posedge clk); model_update(); @(negedge clk);

        // Reset state: everything zero, ready to accept
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wb_result", wb_result, '0);
        chk("rst_wb_dest", wb_dest, '0);
        chk("rst_wb_hi", wb_hi, '0);
        rst = 1'b0;

        // Single transfer, 1-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 5'd3, 32'hDEADBEEF, 5'd0, '0, 2'b01);
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_dest", wb_dest[4:0], 5'd3);
        chk("t1_result", wb_result[DW-1:0], 32'hDEADBEEF);
        chk("t1_we", wb_we, 2'b01);
        tick();

        // Register $0 is never written
        drive(1'b1, 5'd0, 32'h1234, 5'd0, '0, 2'b01);
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        chk("zr_valid", out_valid, 1'b1);
        chk("zr_we", wb_we, 2'b00);
        tick();

        // Backpressure into the skid buffer
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 32'd1, 5'd0, '0, 2'b01); tick();
        drive(1'b1, 5'd2, 32'd2, 5'd0, '0, 2'b01); tick();
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        chk("skid_full_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("skid_hold", wb_result[DW-1:0], 32'd1);
            tick();
        end
        out_ready = 1'b1;
        chk("skid_first", wb_result[DW-1:0], 32'd1);
        tick();
        chk("skid_second", wb_result[DW-1:0], 32'd2);
        chk("skid_ready_back", in_ready, 1'b1);
        tick();

        // Flush while full; C must never appear
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 32'hA, 5'd0, '0, 2'b01); tick();
        drive(1'b1, 5'd8, 32'hB, 5'd0, '0, 2'b01); tick();
        drive(1'b1, 5'd9, 32'hC, 5'd0, '0, 2'b01);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_we", wb_we, 2'b00);
        chk("fl_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_c", out_valid, 1'b0);
        end

        // Two lanes plus HI/LO
        drive(1'b1, 5'd4, 32'h11, 5'd0, 32'h22, 2'b11);
        in_hilo_we = 1'b1; in_hi = 32'hAA; in_lo = 32'hBB;
        tick();
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        chk("ml_we", wb_we, 2'b01);
        chk("ml_result", wb_result, {32'h22, 32'h11});
        chk("ml_hilo_we", wb_hilo_we, 1'b1);
        chk("ml_hi", wb_hi, 32'hAA);
        chk("ml_lo", wb_lo, 32'hBB);
        tick();

        // Reset with entries held discards them
        out_ready = 1'b0;
        drive(1'b1, 5'd5, 32'h55, 5'd6, 32'h66, 2'b11); tick();
        drive(1'b1, 5'd5, 32'h77, 5'd6, 32'h88, 2'b11); tick();
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_valid", out_valid, 1'b0);
        chk("rmid_we", wb_we, 2'b00);
        chk("rmid_hilo_we", wb_hilo_we, 1'b0);
        tick();

        // Full throughput with out_ready held high
        out_ready = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'(i + 1), 32'(i + 100), 5'(i), 32'(i), 2'b11);
            if (i > 0) begin
                chk("tp_ready", in_ready, 1'b1);
                chk("tp_valid", out_valid, 1'b1);
                if (out_valid) done_cnt++;
            end
            tick();
        end
        drive(1'b0, 5'd0, '0, 5'd0, '0, 2'b00);
        if (out_valid) done_cnt++;
        tick();
        chk("tp_count", done_cnt, 20);

        // Random streaming: 100 entries, random stalls on both sides
        stream_on = 1'b1;
        for (int cyc = 0; cyc < 3000 && next_id < 100; cyc++) begin
            in_valid   = (sent_id < 100) && ($urandom_range(0, 3) != 0);
            in_dest    = 10'($urandom);
            in_result  = {$urandom, 32'(sent_id)};
            in_we      = 2'($urandom);
            in_hilo_we = 1'($urandom);
            in_hi      = $urandom;
            in_lo      = $urandom;
            out_ready  = 1'($urandom);
            tick();
        end
        stream_on = 1'b0;
        in_valid = 1'b0;
        chk("stream_sent", sent_id, 100);
        chk("stream_delivered", next_id, 100);
        chk("stream_empty", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM→WB pipeline register, successor to the fixed single-lane dest/result latch. Carries LANES writeback lanes (dest, result, write-enable) plus HI/LO writes. Uses a valid/ready handshake with a 2-entry skid buffer so WB-side backpressure never drops data. Supports a synchronous flush for exceptions and branch recovery.

Parameters:
DATA_W, 32, width of each result word and of HI/LO.
ADDR_W, 5, register-file address width.
LANES, 1, number of parallel writeback lanes (1..4).
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register, in_ready = out_ready || !out_valid.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous kill of all held and incoming entries.
in_valid  in  1  MEM stage presents an entry.
in_ready  out  1  stage can accept this cycle.
in_we  in  LANES  per-lane register write enable.
in_dest  in  LANES*ADDR_W  per-lane destination; lane i = bits [i*ADDR_W +: ADDR_W].
in_result  in  LANES*DATA_W  per-lane result.
in_hilo_we  in  1  HI/LO write enable.
in_hi  in  DATA_W  HI value.
in_lo  in  DATA_W  LO value.
out_valid  out  1  WB entry valid.
out_ready  in  1  WB consumes the entry this cycle.
wb_we  out  LANES  qualified write enable (forced 0 when !out_valid).
wb_dest  out  LANES*ADDR_W  destination.
wb_result  out  LANES*DATA_W  result.
wb_hilo_we  out  1  qualified HI/LO write enable.
wb_hi  out  DATA_W  HI value.
wb_lo  out  DATA_W  LO value.

Behaviour:
- Reset: all registered outputs 0; main_valid = skid_valid = 0; in_ready = 1 the cycle after reset.
- Priority per cycle: rst > flush > transfer.
- Latency: 1 cycle from accepted input (in_valid && in_ready) to out_valid when main is empty or draining.
- Lane write enables are qualified at capture: we[i] is stored as 0 when dest[i] == 0 (register $0 never written).
- SKID_EN=1: in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Accept while main is empty or (out_valid && out_ready): load main.
  - Accept while main is held (out_valid && !out_ready): load skid.
  - Drain with skid_valid && out_ready: main <= skid; skid_valid <= 0, or reload skid if accepting in the same cycle, which cannot happen because in_ready is 0.
  - Full means main and skid both valid; in_ready stays 0 until the first drain.
- SKID_EN=0: single register; in_ready combinational as listed in Parameters.
- Flush: next cycle main_valid = skid_valid = 0 and the input is not captured even if in_valid is high. Data fields may hold stale values, but wb_we and wb_hilo_we must be 0.
- Entries emerge in strict FIFO order. Each accepted entry appears on the outputs exactly once and is consumed exactly once.
- out_* fields are stable while out_valid && !out_ready.
- Reset asserted mid-transfer discards all entries; no partial write reaches WB.

Decomposition:
- Shared package/defines: DATA_W/ADDR_W defaults (existing word and register-address bus widths), a ZERO_REG constant, and the lane-slice macro.
- One sub-module, wb_entry_reg: holds a single entry (valid plus all fields) with load/clear controls. Instantiated twice, as main and skid; only main when SKID_EN=0.

Test Plan:
- Reset, then single transfer: rst=1 for 2 cycles, then in_valid=1, dest=5'd3, result=32'hDEADBEEF, we=1, out_ready=1 -> next cycle out_valid=1, wb_dest=3, wb_result=DEADBEEF, wb_we=1; while rst=1 all outputs are 0.
- Zero-register suppression: dest=0, we=1, result=32'h1234 -> wb_we=0, out_valid=1.
- Backpressure/skid: out_ready=0; send A (result 1) then B (result 2) -> in_ready falls after B. Hold 3 cycles with out_ready=0 -> wb_result stays 1. Raise out_ready -> outputs 1, then 2; in_ready returns to 1.
- Flush while full: main=A, skid=B, in_valid=1 with C, flush=1 -> next cycle out_valid=0, wb_we=0, in_ready=1. C never appears.
- Multi-lane/HI-LO: LANES=2; lane0 (dest 4, 32'h11), lane1 (dest 0, 32'h22); hilo_we=1, hi=32'hAA, lo=32'hBB -> wb_we=2'b01, both lane results present, wb_hilo_we=1, hi=AA, lo=BB.
- Streaming throughput: 100 back-to-back entries with random out_ready -> scoreboard sees in-order, lossless, duplicate-free delivery. With out_ready held at 1, one entry completes per cycle.
